trig_conditioner: RTL and testbench
===================================

TRIG_CONDITIONER -- requirements
Module: trig_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on btn_in (legal range 2..4).
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to accept a level change (legal range 2..65535).
REQ-003 Parameter HOLDOFF_CYCLES, default 8: minimum number of cycles from one trigger to the next (legal range 0..65535).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 btn_in  input  1  raw, asynchronous, bouncing trigger source.
REQ-007 trigger  output  1  registered one-cycle pulse per accepted rising edge; feeds the downstream pulse generator's trigger input.
REQ-008 level  output  1  registered debounced level of btn_in.
REQ-009 dropped  output  1  registered one-cycle pulse when an accepted rising edge is suppressed by holdoff.
REQ-010 trig_count  output  8  count of issued triggers; wraps 255 -> 0.

Function
REQ-011 btn_in shall pass through a SYNC_STAGES-flop synchronizer; no other logic shall sample btn_in directly.
REQ-012 The FSM shall have four states: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-013 In LOW, sync_in=1 shall cause LOW -> RISE_CHK with the debounce counter cleared to 0.
REQ-014 In RISE_CHK, sync_in=0 shall return the FSM to LOW; otherwise the counter increments.
REQ-015 In RISE_CHK, when the counter equals DEBOUNCE_CYCLES-1 and sync_in=1, the FSM shall go to HIGH and level shall be set to 1 on that same edge.
REQ-016 In HIGH, sync_in=0 shall cause HIGH -> FALL_CHK with the counter cleared; in FALL_CHK, sync_in=1 shall return the FSM to HIGH.
REQ-017 In FALL_CHK, when the counter equals DEBOUNCE_CYCLES-1 and sync_in=0, the FSM shall go to LOW and level shall be cleared.
REQ-018 On the RISE_CHK -> HIGH edge with the holdoff counter at 0, trigger shall be 1 for exactly one cycle, trig_count shall increment, and the holdoff counter shall load HOLDOFF_CYCLES.
REQ-019 On the RISE_CHK -> HIGH edge with the holdoff counter nonzero, trigger shall stay 0 and dropped shall pulse for one cycle.
REQ-020 The holdoff counter shall decrement by 1 per cycle while nonzero, independent of FSM state.
REQ-021 Latency: if edge N is the first edge that samples btn_in high and btn_in then stays stable, trigger shall be high in the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-022 A falling edge shall never generate trigger; only level changes.
REQ-023 The debounce counter shall be 16 bits and shall saturate, never wrap, while in any state.
REQ-024 trigger and dropped shall never be high in the same cycle.

Reset
REQ-025 rst_n low shall immediately force: FSM=LOW, synchronizer flops=0, counters=0, trigger=0, level=0, dropped=0, trig_count=0.
REQ-026 Reset asserted mid-debounce or mid-holdoff shall discard all progress; after release, a held-high btn_in shall be requalified from LOW with full latency per REQ-021.
REQ-027 Reset deassertion shall be synchronized externally to clk; the block shall not contain a reset synchronizer.

Structure
REQ-028 The FSM state enumeration and the default parameter constants shall live in shared package trig_pkg.
REQ-029 The synchronizer shall be a separate sub-module, sync_ff (parameterized depth, async active-low reset), instantiated once.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8)
REQ-030 Clean rise: btn_in 0 -> 1 first sampled at edge 10 and held -> trigger high only after edge 16, level=1 from edge 16, trig_count=1.
REQ-031 Bounce: btn_in high for 2 cycles, low for 1, then high and held -> exactly one trigger, 4 stable cycles after the last bounce; the short glitches produce no trigger.
REQ-032 Holdoff: a second clean press is accepted 5 cycles after the first trigger -> dropped pulses once, trigger stays 0, trig_count unchanged; a press accepted 9 or more cycles after the first trigger -> trigger issued.
REQ-033 Release: btn_in falls and stays low -> level=0 after edge +6 from the first low sample, no trigger and no dropped pulse.
REQ-034 Wrap: 256 valid spaced presses -> trig_count returns to 0.
REQ-035 Reset mid-operation: rst_n pulsed low during RISE_CHK with btn_in held high -> all outputs 0 asynchronously; the first trigger appears 6 edges after release.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger conditioner: debounce FSM states,
// default parameter values and the saturating counter helper.
package trig_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int HOLDOFF_CYCLES_DEF  = 8;
    localparam int CNT_W               = 16;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_RISE_CHK = 2'd1,
        ST_HIGH     = 2'd2,
        ST_FALL_CHK = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trig_conditioner.sv
// Debounces a bouncing button, emits one trigger pulse per accepted rising
// edge subject to a holdoff window, and counts issued triggers.
module trig_conditioner
    import trig_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       trigger,
    output logic       level,
    output logic       dropped,
    output logic [7:0] trig_count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

    logic             sync_in;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             trig_q, trig_d;
    logic             drop_q, drop_d;
    logic             level_q, level_d;
    logic [7:0]       count_q, count_d;
    logic             rise_accept, fall_accept;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (btn_in),
        .q_o  (sync_in)
    );

    // NOTE: reset is asynchronous, so it sits in the sensitivity list and
    // clears every flop immediately, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            drop_q  <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            drop_q  <= drop_d;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    // NOTE: each combinational block assigns a default to every output
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOW:      if (sync_in) state_d = ST_RISE_CHK;
            ST_RISE_CHK: if (!sync_in)              state_d = ST_LOW;
                         else if (cnt_q == DEB_LAST) state_d = ST_HIGH;
            ST_HIGH:     if (!sync_in) state_d = ST_FALL_CHK;
            ST_FALL_CHK: if (sync_in)               state_d = ST_HIGH;
                         else if (cnt_q == DEB_LAST) state_d = ST_LOW;
            default:     state_d = ST_LOW;
        endcase
    end

    always_comb begin
        rise_accept = (state_q == ST_RISE_CHK) && (state_d == ST_HIGH);
        fall_accept = (state_q == ST_FALL_CHK) && (state_d == ST_LOW);

        // Any state change restarts the stability count; checks accumulate.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_RISE_CHK || state_q == ST_FALL_CHK) begin
            cnt_d = sat_inc(cnt_q);
        end

        hold_d  = (hold_q == '0) ? hold_q : hold_q - 16'd1;
        trig_d  = 1'b0;
        drop_d  = 1'b0;
        count_d = count_q;
        if (rise_accept) begin
            if (hold_q == '0) begin
                trig_d  = 1'b1;
                hold_d  = HOLD_LOAD;
                count_d = count_q + 8'd1;
            end else begin
                drop_d = 1'b1;
            end
        end

        level_d = level_q;
        if (rise_accept) level_d = 1'b1;
        if (fall_accept) level_d = 1'b0;
    end

    assign trigger    = trig_q;
    assign dropped    = drop_q;
    assign level      = level_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_trig_conditioner.sv
// Randomized and directed bench for trig_conditioner: two instances with
// different parameters, each checked every cycle against a run-length model.
module tb_trig_conditioner;

    localparam int S0 = 2, D0 = 4, H0 = 8;
    localparam int S1 = 3, D1 = 2, H1 = 20;

    int P_S [2] = '{S0, S1};
    int P_D [2] = '{D0, D1};
    int P_H [2] = '{H0, H1};

    logic       clk;
    logic       rst_n;
    logic       btn;
    logic       t0_trig, t0_lvl, t0_drop;
    logic [7:0] t0_cnt;
    logic       t1_trig, t1_lvl, t1_drop;
    logic [7:0] t1_cnt;

    trig_conditioner #(.SYNC_STAGES(S0), .DEBOUNCE_CYCLES(D0), .HOLDOFF_CYCLES(H0)) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .trigger(t0_trig), .level(t0_lvl), .dropped(t0_drop), .trig_count(t0_cnt)
    );

    trig_conditioner #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1), .HOLDOFF_CYCLES(H1)) dut1 (
        .clk(clk), .rst_n(rst_n), .btn_in(btn),
        .trigger(t1_trig), .level(t1_lvl), .dropped(t1_drop), .trig_count(t1_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model: a level flips once DEBOUNCE+1 consecutive synchronized
    // samples disagree with it; a rise issues a trigger only if more than
    // HOLDOFF edges have passed since the previous issued trigger.
    bit [7:0] m_pipe [2];
    bit       m_lvl  [2];
    int       m_run  [2];
    int       m_cnt  [2];
    int       m_last [2];
    bit       m_have [2];
    int       m_cyc = 0;
    bit       e_trig [2];
    bit       e_drop [2];
    int       obs_trig [2];
    int       obs_drop [2];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pipe[i] = '0;
            m_lvl[i]  = 1'b0;
            m_run[i]  = 0;
            m_cnt[i]  = 0;
            m_have[i] = 1'b0;
            e_trig[i] = 1'b0;
            e_drop[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit s;
            s = m_pipe[i][P_S[i]-1];
            m_pipe[i] = {m_pipe[i][6:0], btn};
            e_trig[i] = 1'b0;
            e_drop[i] = 1'b0;
            if (s != m_lvl[i]) m_run[i]++;
            else               m_run[i] = 0;
            if (m_run[i] == P_D[i] + 1) begin
                m_run[i] = 0;
                m_lvl[i] = ~m_lvl[i];
                if (m_lvl[i]) begin
                    if (!m_have[i] || (m_cyc - m_last[i]) > P_H[i]) begin
                        e_trig[i] = 1'b1;
                        m_cnt[i]  = (m_cnt[i] + 1) % 256;
                        m_last[i] = m_cyc;
                        m_have[i] = 1'b1;
                    end else begin
                        e_drop[i] = 1'b1;
                    end
                end
            end
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        check("trig0", int'(t0_trig), int'(e_trig[0]));
        check("lvl0",  int'(t0_lvl),  int'(m_lvl[0]));
        check("drop0", int'(t0_drop), int'(e_drop[0]));
        check("cnt0",  int'(t0_cnt),  m_cnt[0]);
        check("trig1", int'(t1_trig), int'(e_trig[1]));
        check("lvl1",  int'(t1_lvl),  int'(m_lvl[1]));
        check("drop1", int'(t1_drop), int'(e_drop[1]));
        check("cnt1",  int'(t1_cnt),  m_cnt[1]);
    endtask

    task automatic cycle(input logic b);
        btn = b;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        obs_trig[0] += int'(t0_trig);
        obs_drop[0] += int'(t0_drop);
        obs_trig[1] += int'(t1_trig);
        obs_drop[1] += int'(t1_drop);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_trig0", int'(t0_trig), 0);
        check("rst_lvl0",  int'(t0_lvl),  0);
        check("rst_drop0", int'(t0_drop), 0);
        check("rst_cnt0",  int'(t0_cnt),  0);
        check("rst_trig1", int'(t1_trig), 0);
        check("rst_lvl1",  int'(t1_lvl),  0);
        check("rst_drop1", int'(t1_drop), 0);
        check("rst_cnt1",  int'(t1_cnt),  0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    // First press cycle is k=1; the trigger must appear after k = S+D+1.
    task automatic measure_rise(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1);
            if (t0_trig === 1'b1) begin
                lat = k;
                break;
            end
        end
        check(tag, lat, S0 + D0 + 1);
    endtask

    task automatic measure_fall(input string tag);
        int lat;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b0);
            if (t0_lvl === 1'b0) begin
                lat = k;
                break;
            end
        end
        check(tag, lat, S0 + D0 + 1);
    endtask

    initial begin
        int c_trig, c_drop, w_cnt;
        rst_n = 1'b1;
        btn   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_last[i]   = 0;
            obs_trig[i] = 0;
            obs_drop[i] = 0;
        end
        #1;
        do_reset();
        repeat (30) cycle(1'b0);

        // Clean rise, then release.
        measure_rise("lat_clean");
        check("cnt_after_clean", int'(t0_cnt), 1);
        repeat (5) cycle(1'b1);
        c_trig = obs_trig[0];
        c_drop = obs_drop[0];
        measure_fall("lat_release");
        check("release_trigs", obs_trig[0] - c_trig, 0);
        check("release_drops", obs_drop[0] - c_drop, 0);
        repeat (30) cycle(1'b0);

        // Bounce: 1,1,0 then held high.
        c_trig = obs_trig[0];
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        measure_rise("lat_bounce");
        repeat (3) cycle(1'b1);
        check("bounce_trigs", obs_trig[0] - c_trig, 1);
        repeat (30) cycle(1'b0);

        // Holdoff on the long-holdoff instance: second press is dropped.
        c_trig = obs_trig[1];
        c_drop = obs_drop[1];
        repeat (6) cycle(1'b1);
        repeat (6) cycle(1'b0);
        repeat (6) cycle(1'b1);
        check("hold_drop", obs_drop[1] - c_drop, 1);
        check("hold_trig", obs_trig[1] - c_trig, 1);
        repeat (30) cycle(1'b0);
        repeat (6) cycle(1'b1);
        check("hold_retrig", obs_trig[1] - c_trig, 2);
        check("hold_drop_final", obs_drop[1] - c_drop, 1);
        repeat (30) cycle(1'b0);

        // Random bouncing segments.
        for (int seg = 0; seg < 150; seg++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 10)) cycle(b);
        end

        // Reset during RISE_CHK with the button held high.
        repeat (30) cycle(1'b0);
        repeat (3) cycle(1'b1);
        do_reset();
        measure_rise("lat_after_rst");
        repeat (30) cycle(1'b0);

        // Wrap: 256 well-spaced presses return the counter to its start.
        w_cnt  = int'(t0_cnt);
        c_trig = obs_trig[0];
        for (int p = 0; p < 256; p++) begin
            repeat (5 + $urandom_range(0, 3)) cycle(1'b1);
            repeat (5 + $urandom_range(0, 3)) cycle(1'b0);
        end
        repeat (10) cycle(1'b0);
        check("wrap_cnt", int'(t0_cnt), w_cnt);
        check("wrap_trigs", obs_trig[0] - c_trig, 256);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
